// File: rtl/axi4_master_arbiter.sv
// axi4_master_arbiter
//   Shares one slave memory port between N_REQ requesters. The winner is
//   picked round-robin, and its single-word read or write is driven onto the
//   slave pins as SETUP -> ENABLE -> RESP. Completion (and, for reads, the
//   data) goes back to that requester.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req/req_we/req_addr/req_wdata  per-requester request fields (packed)
//   gnt, done                      one-hot 1-cycle grant / completion pulses
//   rdata                          read data, updated on read completion only
//   busy                           high while a transfer is in flight
//   psel/penable/pwrite/paddr/pwdata/prdata  slave memory port
module axi4_master_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        busy,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [ADDR_WIDTH-1:0]       paddr,
    output logic [DATA_WIDTH-1:0]       pwdata,
    input  logic [DATA_WIDTH-1:0]       prdata
);
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ENABLE = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    typedef struct packed {
        logic [LW-1:0]         owner;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } xfer_t;

    logic [1:0]                           state;
    logic [LW-1:0]                        last;
    xfer_t                                cur;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0]     addr_a;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_a;
    logic [LW-1:0]                        win;
    logic                                 found;
    logic [N_REQ-1:0]                     win_oh;
    int                                   idx;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    // Slave address/data/direction come straight from the latched transfer,
    // so they naturally hold through RESP and IDLE.
    assign pwrite = cur.we;
    assign paddr  = cur.addr;
    assign pwdata = cur.wdata;

    // Round-robin pick: first set req bit starting just after the last winner.
    always_comb begin
        win    = '0;
        found  = 1'b0;
        win_oh = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(last) + 1 + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = LW'(idx);
            end
        end
        if (found) win_oh[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= LW'(N_REQ - 1);
            cur     <= '0;
            gnt     <= '0;
            done    <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            psel    <= 1'b0;
            penable <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE, RESP: begin
                    if (state == RESP) begin
                        done[cur.owner] <= 1'b1;
                        if (!cur.we) rdata <= prdata;
                    end
                    // Arbitrating on the RESP edge too gives back-to-back
                    // transfers with no idle bubble.
                    if (found) begin
                        state     <= SETUP;
                        last      <= win;
                        cur.owner <= win;
                        cur.we    <= req_we[win];
                        cur.addr  <= addr_a[win];
                        cur.wdata <= wdata_a[win];
                        gnt       <= win_oh;
                        busy      <= 1'b1;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                SETUP: begin
                    state   <= ENABLE;
                    penable <= 1'b1;
                end
                ENABLE: begin
                    state   <= RESP;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_master_arbiter.sv
// Bench for axi4_master_arbiter: behavioural slave memory, a transaction-level
// schedule model compared every cycle, and directed literal checks.
module tb_axi4_master_arbiter;
    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int MAXC = 2048;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_we = '0;
    logic [N*AW-1:0]  req_addr = '0;
    logic [N*DW-1:0]  req_wdata = '0;
    logic [N-1:0]     gnt, done;
    logic [DW-1:0]    rdata;
    logic             busy, psel, penable, pwrite;
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic [DW-1:0]    prdata = '0;

    int n_cmp = 0;
    int n_bad = 0;

    axi4_master_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rdata(rdata), .busy(busy), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave memory: commits writes / registers read data at the ENABLE edge.
    bit [DW-1:0] smem [256];
    initial forever begin
        @(posedge clk);
        if (rst_n && psel && penable) begin
            if (pwrite) smem[paddr] <= pwdata;
            else        prdata      <= smem[paddr];
        end
    end

    // Model: one transfer at a time; a grant decided at the end of cycle c
    // fixes the whole timeline c+1..c+4 from the spec's latency table.
    bit [DW-1:0] mm [256];
    bit [N-1:0]  e_gnt [MAXC];
    bit [N-1:0]  e_done [MAXC];
    bit          e_psel [MAXC];
    bit          e_pen [MAXC];
    bit          e_busy [MAXC];
    bit          e_rdv [MAXC];
    bit [DW-1:0] e_rdval [MAXC];
    bit [AW-1:0] m_paddr;
    bit          m_pwrite;
    bit [DW-1:0] m_pwdata, m_rdata;
    int          cyc = 0;
    int          arb_at = 0;
    int          last_m = N - 1;

    initial forever begin
        int c, w;
        bit [AW-1:0] a;
        @(posedge clk);
        c = cyc;
        if (!rst_n) arb_at = c + 1;
        else if (c == arb_at) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && req[(last_m + k) % N]) w = (last_m + k) % N;
            if (w < 0) arb_at = c + 1;
            else begin
                a = req_addr[w*AW +: AW];
                e_gnt[c+1][w] = 1'b1;
                e_psel[c+1] = 1'b1; e_psel[c+2] = 1'b1; e_pen[c+2] = 1'b1;
                for (int k = 1; k <= 3; k++) e_busy[c+k] = 1'b1;
                m_paddr  = a;
                m_pwrite = req_we[w];
                m_pwdata = req_wdata[w*DW +: DW];
                if (req_we[w]) mm[a] = m_pwdata;
                else begin e_rdv[c+4] = 1'b1; e_rdval[c+4] = mm[a]; end
                e_done[c+4][w] = 1'b1;
                last_m = w;
                arb_at = c + 3;
            end
        end
        cyc = c + 1;
    end

    // Reset abandons everything scheduled from the current cycle onward.
    initial forever begin
        @(negedge rst_n);
        for (int k = cyc; k < MAXC; k++) begin
            e_gnt[k] = '0; e_done[k] = '0; e_psel[k] = 0; e_pen[k] = 0;
            e_busy[k] = 0; e_rdv[k] = 0;
        end
        m_paddr = '0; m_pwrite = 0; m_pwdata = '0; m_rdata = '0;
        last_m = N - 1;
    end

    initial forever begin
        int k;
        @(negedge clk);
        k = cyc;
        if (e_rdv[k]) m_rdata = e_rdval[k];
        chk("gnt",     64'(gnt),     64'(e_gnt[k]));
        chk("done",    64'(done),    64'(e_done[k]));
        chk("busy",    64'(busy),    64'(e_busy[k]));
        chk("psel",    64'(psel),    64'(e_psel[k]));
        chk("penable", 64'(penable), 64'(e_pen[k]));
        chk("pwrite",  64'(pwrite),  64'(m_pwrite));
        chk("paddr",   64'(paddr),   64'(m_paddr));
        chk("pwdata",  64'(pwdata),  64'(m_pwdata));
        chk("rdata",   64'(rdata),   64'(m_rdata));
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1; req_we[i] = we;
        req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        smem[a] = d; mm[a] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int gq[$], gc[$];
        logic [DW-1:0] rq[$];
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_psel", 64'(psel), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        rst_n = 1'b1;

        // 1: write 0xDEADBEEF to 0x10 from requester 0
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        tick();
        chk("t1_gnt", 64'(gnt), 64'(4'b0001));
        chk("t1_setup", 64'({psel, penable}), 64'(2'b10));
        req[0] = 1'b0;
        tick();
        chk("t1_enable", 64'({psel, penable}), 64'(2'b11));
        tick();
        chk("t1_resp", 64'({busy, psel, penable}), 64'(3'b100));
        tick();
        chk("t1_done", 64'(done), 64'(4'b0001));
        chk("t1_mem", 64'(smem[8'h10]), 64'(32'hDEADBEEF));

        // 2: requester 2 reads it back; rdata then holds
        set_req(2, 1'b0, 8'h10, '0);
        tick();
        chk("t2_gnt", 64'(gnt), 64'(4'b0100));
        req[2] = 1'b0;
        repeat (3) tick();
        chk("t2_done", 64'(done), 64'(4'b0100));
        chk("t2_rdata", 64'(rdata), 64'(32'hDEADBEEF));
        repeat (2) tick();
        chk("t2_hold", 64'(rdata), 64'(32'hDEADBEEF));

        // 3: all four read continuously; pointer restarted by reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            preload(i, 32'hA0 + 32'(i));
            set_req(i, 1'b0, 8'(i), '0);
        end
        for (int c = 1; c <= 15; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (gnt[i]) begin gq.push_back(i); gc.push_back(c); end
            if (done != '0) rq.push_back(rdata);
        end
        req = '0;
        for (int t = 0; t < 10 && busy; t++) tick();
        chk("t3_idle", 64'(busy), 64'(0));
        chk("t3_ngnt", 64'(gq.size()), 64'(5));
        chk("t3_ndone", 64'(rq.size()), 64'(4));
        if (gq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t3_order", 64'(gq[i]), 64'(i % 4));
                chk("t3_cycle", 64'(gc[i]), 64'(1 + 3 * i));
            end
        end
        if (rq.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_rdata", 64'(rq[i]), 64'(32'hA0 + i));
        tick();

        // 4: last=1, then 1 and 3 together -> 3 first, 1 back-to-back
        set_req(1, 1'b0, 8'h00, '0);
        tick();
        chk("t4_pre_gnt", 64'(gnt), 64'(4'b0010));
        req[1] = 1'b0;
        repeat (3) tick();
        set_req(1, 1'b0, 8'h01, '0);
        set_req(3, 1'b0, 8'h03, '0);
        tick();
        chk("t4_gnt3", 64'(gnt), 64'(4'b1000));
        req[3] = 1'b0;
        repeat (3) tick();
        chk("t4_gnt1", 64'(gnt), 64'(4'b0010));
        chk("t4_done3", 64'(done), 64'(4'b1000));
        chk("t4_rd3", 64'(rdata), 64'(32'hA3));
        req[1] = 1'b0;
        repeat (3) tick();
        chk("t4_done1", 64'(done), 64'(4'b0010));
        chk("t4_rd1", 64'(rdata), 64'(32'hA1));

        // 5: reset during ENABLE of a write
        set_req(0, 1'b1, 8'h20, 32'h55AA55AA);
        tick();
        req[0] = 1'b0;
        tick();
        chk("t5_in_enable", 64'(penable), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_zero", 64'({gnt, done, busy, psel, penable, pwrite}), 64'(0));
        chk("t5_async_bus", 64'({paddr, pwdata}), 64'(0));
        chk("t5_async_rdata", 64'(rdata), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        chk("t5_nowrite", 64'(smem[8'h20]), 64'(0));
        set_req(0, 1'b0, 8'h10, '0);
        tick();
        chk("t5_gnt", 64'(gnt), 64'(4'b0001));
        chk("t5_setup", 64'({psel, penable}), 64'(2'b10));
        req[0] = 1'b0;
        tick();
        chk("t5_enable", 64'({psel, penable}), 64'(2'b11));
        tick();
        chk("t5_resp", 64'({busy, psel}), 64'(2'b10));
        tick();
        chk("t5_done", 64'(done), 64'(4'b0001));
        chk("t5_rdata", 64'(rdata), 64'(32'hDEADBEEF));

        // 6: top address write/read, then a write must not touch rdata
        set_req(1, 1'b1, 8'hFF, 32'h12345678);
        tick();
        chk("t6_paddr", 64'(paddr), 64'(8'hFF));
        req[1] = 1'b0;
        repeat (3) tick();
        set_req(2, 1'b0, 8'hFF, '0);
        tick();
        req[2] = 1'b0;
        repeat (3) tick();
        chk("t6_done", 64'(done), 64'(4'b0100));
        chk("t6_rdata", 64'(rdata), 64'(32'h12345678));
        set_req(3, 1'b1, 8'h05, 32'hCAFEF00D);
        tick();
        req[3] = 1'b0;
        repeat (3) tick();
        chk("t6_wdone", 64'(done), 64'(4'b1000));
        chk("t6_rhold", 64'(rdata), 64'(32'h12345678));
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_master_arbiter.md
Name: axi4_master_arbiter

Overview:
Round-robin arbiter and transfer sequencer that shares one axi4_slave memory port between N_REQ requesters. It accepts single-word read/write requests and drives the slave's psel/penable/pwrite/paddr/pwdata pins as a SETUP→ENABLE→RESP sequence. It captures prdata and returns completion and read data to the granted requester. It sits between CPU-side requesters (cores, DMA, debug) and the slave memory.

Parameters:
N_REQ, 4, number of requesters (1..16)
ADDR_WIDTH, 8, slave address width (matches paddr)
DATA_WIDTH, 32, data width (matches pwdata/prdata)

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request, level
req_we  input  N_REQ  per-requester 1=write, 0=read
req_addr  input  N_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  N_REQ*DATA_WIDTH  packed write data, same packing
gnt  output  N_REQ  one-hot 1-cycle pulse; request fields captured
done  output  N_REQ  one-hot 1-cycle completion pulse
rdata  output  DATA_WIDTH  read data, valid when done is high for a read
busy  output  1  high in SETUP/ENABLE/RESP
psel  output  1  slave select
penable  output  1  slave enable
pwrite  output  1  slave direction
paddr  output  ADDR_WIDTH  slave address
pwdata  output  DATA_WIDTH  slave write data
prdata  input  DATA_WIDTH  slave read data

Behaviour:
- Reset (async, any state) clears the following:
  - all outputs to 0; state to IDLE
  - round-robin pointer last to N_REQ-1, so requester 0 wins first
  - internal owner/we/addr/wdata registers to 0
- A request arriving mid-transfer during reset is dropped; no done is issued.
- FSM states: IDLE, SETUP, ENABLE, RESP. All outputs are registered.
- Arbitration is evaluated at the clock edge ending IDLE or RESP, when any req bit is set:
  - Winner g is the first set req bit scanning from (last+1) mod N_REQ upward with wrap.
  - Latch req_we[g], req_addr[g], req_wdata[g] and owner=g; set last=g.
  - Next state is SETUP; gnt[g]=1 for that SETUP cycle only.
  - If no req bit is set, go to or stay in IDLE.
- SETUP: psel=1, penable=0, pwrite/paddr/pwdata=latched values. Next state is ENABLE unconditionally.
- ENABLE: psel=1, penable=1, other slave pins held. Next state is RESP. The slave commits the write, or registers prdata, at this edge.
- RESP: psel=0, penable=0; paddr/pwrite/pwdata hold their last values.
  - At the edge ending RESP: done[owner]<=1 for one cycle.
  - If the latched transfer is a read, rdata<=prdata; on writes rdata is unchanged.
  - Arbitration is performed at the same edge (back-to-back allowed).
- rdata holds its value until the next read completion.
- Throughput: 3 cycles per transfer when continuously requested.
- Latency: req high in IDLE at cycle 0 → gnt cycle 1 (SETUP) → ENABLE cycle 2 → RESP cycle 3 → done cycle 4.
- Requester rules:
  - req_we/addr/wdata must be stable while req is high until gnt.
  - The requester must deassert req, or present a new request, starting the cycle after gnt.
  - A req still high at the RESP edge is a new request.
- Simultaneous requests are resolved strictly by the round-robin order; no requester waits more than N_REQ-1 transfers.
- busy=1 exactly when state is not IDLE.
- psel never drops between SETUP and ENABLE of one transfer; penable is never 1 without psel.

Test Plan:
1. Reset, req[0]=1 write addr 0x10 data 0xDEADBEEF, dropped after gnt → gnt[0] cycle 1; psel=1/penable=0 cycle 1, penable=1 cycle 2; done[0] cycle 4; slave mem[0x10]=0xDEADBEEF.
2. After test 1, req[2] read addr 0x10 → gnt[2], done[2] 4 cycles later with rdata=0xDEADBEEF; rdata held until the next read done.
3. All 4 req high continuously (all reads, addrs 0..3 preloaded with 0xA0..0xA3) → gnt order 0,1,2,3,0; gnt pulses 3 cycles apart; each done carries the matching 0xA0..0xA3.
4. req[1] and req[3] asserted in the same cycle with last=1 → req[3] granted first, then req[1] immediately on the RESP edge (no IDLE cycle).
5. Assert rst_n=0 during ENABLE of a write → all outputs 0 asynchronously; no done pulse; after release, a req[0] read goes through the full SETUP/ENABLE/RESP sequence.
6. Write 0x12345678 to 0xFF, then read 0xFF (address wrap boundary) → rdata=0x12345678; a write in between leaves rdata unchanged.
